pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Handshaked pipeline-stage controller wrapping the 32-bit stage register used between processor pipeline stages.
- Sequences loading of a main data register and a one-entry skid register from valid/ready handshakes, so downstream back-pressure never drops or duplicates a word.
- Supports a synchronous flush for branch/exception squash.
- Counts downstream stall cycles for performance debug.

Parameters:
- WIDTH, 32, data path width in bits.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous squash; discards all held data.
- in_valid  input  1  upstream word present.
- in_ready  output  1  stage can accept a word this cycle.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  WIDTH  stage register contents.
- occupancy  output  2  words held: 0, 1 or 2.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = EMPTY; main and skid registers = 0.
  - out_valid = 0, in_ready = 1, occupancy = 0, stall_cnt = 0.
  - Reset mid-transfer loses held words without any handshake.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- All outputs are derived from registers only; there are no combinational paths from inputs to outputs.
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
  - out_data = main.
  - occupancy = 0 / 1 / 2 for EMPTY / BUSY / FULL.
- States and transitions (evaluated at posedge clk, when flush = 0):
  - EMPTY:
    - in_fire: main <= in_data, go to BUSY.
    - Otherwise stay in EMPTY.
  - BUSY:
    - in_fire & out_fire: main <= in_data, stay in BUSY.
    - in_fire & !out_fire: skid <= in_data, go to FULL.
    - !in_fire & out_fire: go to EMPTY.
    - Neither: hold.
  - FULL (in_ready = 0, so no in_fire is possible):
    - out_fire: main <= skid, go to BUSY.
    - Otherwise hold.
- Latency: a word accepted in cycle N while EMPTY is presented with out_valid = 1 in cycle N+1. Throughput is 1 word/cycle while out_ready stays high.
- Ordering is strictly FIFO. The skid word is always emitted after the main word.
- Stability: while out_valid & !out_ready, out_data and out_valid hold unchanged.
- Flush:
  - Has highest priority after reset. Next state is EMPTY; main and skid keep stale values but are invalid.
  - Any in_fire or out_fire in the flush cycle is void.
  - in_ready is 1 in the following cycle.
  - stall_cnt is not cleared by flush.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & !out_ready & !flush.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Data is passed through unmodified; no arithmetic is applied to data.

Test Plan:
- Reset, then in_valid = 1 with in_data = 0x0000_00A5 and out_ready = 1 -> next cycle out_valid = 1, out_data = 0x0000_00A5, occupancy = 1.
- Streaming 0x1..0x8 on back-to-back cycles with out_ready = 1 -> outputs 0x1..0x8 on consecutive cycles; in_ready stays 1; stall_cnt = 0.
- Send 0x11, 0x22 with out_ready = 0 -> occupancy = 2, in_ready = 0, out_data = 0x11 held. Then raise out_ready -> 0x11 then 0x22 are emitted; stall_cnt equals the number of stalled valid cycles.
- In FULL, assert flush for 1 cycle with in_valid = 1 and in_data = 0x33 -> next cycle out_valid = 0, occupancy = 0, in_ready = 1; 0x33 is never emitted.
- Drop rst_n asynchronously mid-cycle while FULL -> outputs go to their reset values immediately, without waiting for a clock edge.
- Force CNT_W = 4 and hold out_ready = 0 for 20 cycles with a valid word held -> stall_cnt = 15 and stays at 15.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a one-entry skid buffer.
//
// Handshake (both ports): a word moves across a port on a rising clk edge
// exactly when valid and ready are both high in the preceding cycle. A valid
// producer keeps valid high and its data stable until the transfer happens.
// Ready never depends combinationally on valid, in either direction.
//
// The stage holds up to two words: "main" is always the word presented
// downstream, and "skid" catches the one extra word accepted in the cycle
// in which downstream stalled. The FSM state is exposed through occupancy
// (0/1/2 for EMPTY/BUSY/FULL). Every output decodes only registers.
module pipe_skid_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic in_fire;
  logic out_fire;
  logic stalled;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Output decode from the state register only.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign stalled  = out_valid & ~out_ready & ~flush;

  // Stage controller: loads main/skid and steps EMPTY/BUSY/FULL. A flush
  // empties the stage but leaves stale data in the registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the downstream side can move.
          if (out_fire) begin
            main_q <= skid_q;
            state  <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where a valid word waits on downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed vectors, scoreboard queue on output.
module tb_pipe_skid_stage;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  // Narrow-counter instance sharing all inputs.
  logic          in_ready4;
  logic          out_valid4;
  logic [W-1:0]  out_data4;
  logic [1:0]    occupancy4;
  logic [3:0]    stall_cnt4;

  pipe_skid_stage #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.WIDTH(W), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor on the falling edge: a transfer seen here completes at the next
  // rising edge. Flush or reset discards every word still held.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL out_unexpected: got 0x%0h expected no output at %0t", out_data, $time);
        end else begin
          chk("out_data_order", out_data, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    rst_n = 1'b1;

    // Single word latency.
    drive(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data",  out_data,           32'h0000_00A5);
    chk("t1_occupancy", {30'd0, occupancy}, 32'd1);
    step();

    // Back-to-back streaming.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("t2_out_data", out_data, W'(i));
      chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("t2_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Fill the skid under back-pressure, then drain.
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t3_occupancy", {30'd0, occupancy}, 32'd2);
    chk("t3_in_ready",  {31'd0, in_ready},  32'd0);
    chk("t3_out_data",  out_data,           32'h11);
    chk("t3_stall1",    {16'd0, stall_cnt}, 32'd1);
    step();
    chk("t3_hold_data", out_data,           32'h11);
    chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_stall2",    {16'd0, stall_cnt}, 32'd2);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("t3_skid_data", out_data,           32'h22);
    chk("t3_occ_busy",  {30'd0, occupancy}, 32'd1);
    step();
    chk("t3_occ_empty", {30'd0, occupancy}, 32'd0);
    chk("t3_stall_fin", {16'd0, stall_cnt}, 32'd2);

    // Flush while FULL with a word offered upstream.
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h33, 1'b0, 1'b1);
    chk("t4_full_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_occupancy", {30'd0, occupancy}, 32'd0);
    chk("t4_in_ready",  {31'd0, in_ready},  32'd1);
    chk("t4_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    // Flush while EMPTY voids an otherwise accepted word.
    drive(1'b1, 32'h66, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("t4_void_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("t4_void_occ",   {30'd0, occupancy}, 32'd0);

    // Asynchronous reset while FULL.
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h88, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t5_pre_occ",   {30'd0, occupancy}, 32'd2);
    chk("t5_pre_stall", {16'd0, stall_cnt}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_in_ready",  {31'd0, in_ready},  32'd1);
    chk("t5_occupancy", {30'd0, occupancy}, 32'd0);
    chk("t5_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("t5_out_data",  out_data,           32'd0);
    step();
    rst_n = 1'b1;

    // Saturation of a 4-bit counter.
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step();
    chk("t6_cnt4_14", {28'd0, stall_cnt4}, 32'd14);
    for (int i = 0; i < 6; i++) step();
    chk("t6_cnt4_20", {28'd0, stall_cnt4}, 32'd15);
    chk("t6_cnt16_20", {16'd0, stall_cnt}, 32'd20);
    for (int i = 0; i < 3; i++) step();
    chk("t6_cnt4_sat", {28'd0, stall_cnt4}, 32'd15);
    chk("t6_cnt16_23", {16'd0, stall_cnt}, 32'd23);
    chk("t6_held",     out_data,            32'h99);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("t6_drained", {31'd0, out_valid}, 32'd0);
    step();

    chk("sb_empty", W'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
